square_plotter: RTL and testbench

- Downstream stage of the game's direction/colour state machine.
- Accepts one (x, y, colour) request naming the top-left corner of a direction square.
- Scans a SIZE x SIZE pixel block in row-major order, emitting one pixel per clock to the VGA adapter's plot/x/y/colour inputs.
- Reports busy/done so the upstream FSM sequences its draw and change states against completed squares.

---
 rtl/square_plotter.sv | 176 +++++++++++++++++
 tb/tb_square_plotter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/square_plotter.sv
// square_plotter
//   Scans a SIZE x SIZE block of pixels in row-major order starting at a
//   latched top-left corner, emitting one pixel per clock to a VGA adapter.
//   Handshake toward the upstream FSM is busy (scan in progress) and a
//   one-cycle done pulse after the last pixel.
//
//   Optional feature macro: SQUARE_PLOTTER_OUTLINE_EN
//     defined   -> only border pixels assert plot (interior still scanned)
//     undefined -> filled square, every pixel plotted
//
// Ports
//   clock      in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   start      in   request strobe, honoured only when idle
//   in_x       in   [X_W-1:0] top-left x
//   in_y       in   [Y_W-1:0] top-left y
//   in_color   in   [C_W-1:0] fill colour
//   busy       out  high while the square is being scanned
//   done       out  one-cycle pulse after the last pixel
//   plot       out  pixel write enable
//   vga_x      out  [X_W-1:0] pixel x
//   vga_y      out  [Y_W-1:0] pixel y
//   vga_color  out  [C_W-1:0] pixel colour
module square_plotter #(
  parameter int SIZE = 4,
  parameter int X_W  = 8,
  parameter int Y_W  = 7,
  parameter int C_W  = 3
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic [X_W-1:0] in_x,
  input  logic [Y_W-1:0] in_y,
  input  logic [C_W-1:0] in_color,
  output logic           busy,
  output logic           done,
  output logic           plot,
  output logic [X_W-1:0] vga_x,
  output logic [Y_W-1:0] vga_y,
  output logic [C_W-1:0] vga_color
);

  localparam int              CW   = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [CW-1:0]   LAST = CW'(SIZE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAW,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cx_q, cx_d;
  logic [CW-1:0]  cy_q, cy_d;
  logic [X_W-1:0] base_x_q, base_x_d;
  logic [Y_W-1:0] base_y_q, base_y_d;
  logic [C_W-1:0] color_q, color_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           plot_q, plot_d;
  logic [X_W-1:0] vga_x_q, vga_x_d;
  logic [Y_W-1:0] vga_y_q, vga_y_d;
  logic [C_W-1:0] vga_color_q, vga_color_d;

  // Whether the pixel at (cx, cy) is written.
  function automatic logic pixel_on(input logic [CW-1:0] cx, input logic [CW-1:0] cy);
`ifdef SQUARE_PLOTTER_OUTLINE_EN
    return (cx == '0) || (cx == LAST) || (cy == '0) || (cy == LAST);
`else
    return 1'b1;
`endif
  endfunction

  // The counters always hold the coordinates of the pixel currently on the
  // outputs; next-pixel outputs are computed from the next counter values so
  // every output stays registered.
  always_comb begin
    state_d     = state_q;
    cx_d        = cx_q;
    cy_d        = cy_q;
    base_x_d    = base_x_q;
    base_y_d    = base_y_q;
    color_d     = color_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    plot_d      = 1'b0;
    vga_x_d     = vga_x_q;
    vga_y_d     = vga_y_q;
    vga_color_d = vga_color_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_DRAW;
          base_x_d    = in_x;
          base_y_d    = in_y;
          color_d     = in_color;
          cx_d        = '0;
          cy_d        = '0;
          busy_d      = 1'b1;
          plot_d      = pixel_on('0, '0);
          vga_x_d     = in_x;
          vga_y_d     = in_y;
          vga_color_d = in_color;
        end
      end

      S_DRAW: begin
        if ((cx_q == LAST) && (cy_q == LAST)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          busy_d = 1'b1;
          if (cx_q == LAST) begin
            cx_d = '0;
            cy_d = cy_q + CW'(1);
          end else begin
            cx_d = cx_q + CW'(1);
          end
          // Coordinate overflow wraps by truncation; no clipping.
          vga_x_d     = base_x_q + X_W'(cx_d);
          vga_y_d     = base_y_q + Y_W'(cy_d);
          vga_color_d = color_q;
          plot_d      = pixel_on(cx_d, cy_d);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cx_q        <= '0;
      cy_q        <= '0;
      base_x_q    <= '0;
      base_y_q    <= '0;
      color_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      plot_q      <= 1'b0;
      vga_x_q     <= '0;
      vga_y_q     <= '0;
      vga_color_q <= '0;
    end else begin
      state_q     <= state_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      base_x_q    <= base_x_d;
      base_y_q    <= base_y_d;
      color_q     <= color_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      plot_q      <= plot_d;
      vga_x_q     <= vga_x_d;
      vga_y_q     <= vga_y_d;
      vga_color_q <= vga_color_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign plot      = plot_q;
  assign vga_x     = vga_x_q;
  assign vga_y     = vga_y_q;
  assign vga_color = vga_color_q;

endmodule

// File: tb/tb_square_plotter.sv
// tb_square_plotter
//   Directed bench for square_plotter (SIZE=4, X_W=8, Y_W=7, C_W=3).
//   Inputs are driven and outputs sampled on the falling clock edge.
//   Honours SQUARE_PLOTTER_OUTLINE_EN for the expected plot pattern.
module tb_square_plotter;

  localparam int SIZE = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] in_x;
  logic [6:0] in_y;
  logic [2:0] in_color;
  logic       busy;
  logic       done;
  logic       plot;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_color;

  integer checks   = 0;
  integer failures = 0;

  square_plotter #(
    .SIZE(SIZE),
    .X_W (8),
    .Y_W (7),
    .C_W (3)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .in_x     (in_x),
    .in_y     (in_y),
    .in_color (in_color),
    .busy     (busy),
    .done     (done),
    .plot     (plot),
    .vga_x    (vga_x),
    .vga_y    (vga_y),
    .vga_color(vga_color)
  );

  always #5 clock = ~clock;

  // Expected plot for pixel n of a SIZE x SIZE scan.
  function automatic logic exp_plot(input int n);
`ifdef SQUARE_PLOTTER_OUTLINE_EN
    int cx;
    int cy;
    cx = n % SIZE;
    cy = n / SIZE;
    return (cx == 0) || (cx == SIZE - 1) || (cy == 0) || (cy == SIZE - 1);
`else
    return 1'b1;
`endif
  endfunction

  task automatic test_reset();
    reset    = 1'b1;
    start    = 1'b0;
    in_x     = '0;
    in_y     = '0;
    in_color = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({busy, done, plot, vga_x, vga_y, vga_color} !== 21'd0) begin
      failures++;
      $display("FAIL reset_state got busy=%b done=%b plot=%b x=%0d y=%0d c=%b want all zero",
               busy, done, plot, vga_x, vga_y, vga_color);
    end
    reset = 1'b0;
  endtask

  // Filled square at (78,54) with start pulses during pixel 5 and in DONE,
  // then a start one cycle after DONE that must be accepted.
  task automatic test_filled_and_ignore();
    logic [7:0] ex;
    logic [6:0] ey;
    @(negedge clock);
    start = 1'b1; in_x = 8'd78; in_y = 7'd54; in_color = 3'b010;
    for (int n = 0; n < 16; n++) begin
      @(negedge clock);
      start = 1'b0; in_x = 8'd78;
      if (n == 5) begin start = 1'b1; in_x = 8'd82; end
      ex = 8'(78 + n % SIZE);
      ey = 7'(54 + n / SIZE);
      checks++;
      if ({plot, busy, done, vga_x, vga_y, vga_color} !== {exp_plot(n), 1'b1, 1'b0, ex, ey, 3'b010}) begin
        failures++;
        $display("FAIL filled_px%0d got plot=%b busy=%b done=%b x=%0d y=%0d c=%b want plot=%b busy=1 done=0 x=%0d y=%0d c=010",
                 n, plot, busy, done, vga_x, vga_y, vga_color, exp_plot(n), ex, ey);
      end
    end
    @(negedge clock);
    checks++;
    if ({busy, done, plot} !== 3'b010) begin
      failures++;
      $display("FAIL filled_done got busy=%b done=%b plot=%b want busy=0 done=1 plot=0", busy, done, plot);
    end
    start = 1'b1; in_x = 8'd82;  // lands in DONE, must be ignored
    @(negedge clock);
    checks++;
    if ({busy, done, plot} !== 3'b000) begin
      failures++;
      $display("FAIL ignore_in_done got busy=%b done=%b plot=%b want 000", busy, done, plot);
    end
    // start still high: sampled in IDLE now, accepted
    @(negedge clock);
    start = 1'b0;
    checks++;
    if ({plot, busy, vga_x, vga_y, vga_color} !== {1'b1, 1'b1, 8'd82, 7'd54, 3'b010}) begin
      failures++;
      $display("FAIL accept_after_done got plot=%b busy=%b x=%0d y=%0d c=%b want plot=1 busy=1 x=82 y=54 c=010",
               plot, busy, vga_x, vga_y, vga_color);
    end
    repeat (15) @(negedge clock);
    @(negedge clock);
    checks++;
    if ({busy, done, plot} !== 3'b010) begin
      failures++;
      $display("FAIL accept_after_done_end got busy=%b done=%b plot=%b want 010", busy, done, plot);
    end
    @(negedge clock);
  endtask

  task automatic test_wrap();
    logic [7:0] ex;
    logic [6:0] ey;
    start = 1'b1; in_x = 8'd254; in_y = 7'd126; in_color = 3'b101;
    for (int n = 0; n < 16; n++) begin
      @(negedge clock);
      start = 1'b0;
      ex = 8'(254 + n % SIZE);
      ey = 7'(126 + n / SIZE);
      checks++;
      if ({plot, busy, done, vga_x, vga_y, vga_color} !== {exp_plot(n), 1'b1, 1'b0, ex, ey, 3'b101}) begin
        failures++;
        $display("FAIL wrap_px%0d got plot=%b busy=%b done=%b x=%0d y=%0d c=%b want plot=%b busy=1 done=0 x=%0d y=%0d c=101",
                 n, plot, busy, done, vga_x, vga_y, vga_color, exp_plot(n), ex, ey);
      end
    end
    @(negedge clock);
    checks++;
    if ({busy, done, plot} !== 3'b010) begin
      failures++;
      $display("FAIL wrap_done got busy=%b done=%b plot=%b want 010", busy, done, plot);
    end
    @(negedge clock);
  endtask

  task automatic test_reset_mid();
    logic       saw_activity;
    logic [7:0] ex;
    logic [6:0] ey;
    start = 1'b1; in_x = 8'd10; in_y = 7'd20; in_color = 3'b001;
    for (int n = 0; n < 8; n++) begin
      @(negedge clock);
      start = 1'b0;
      if (n == 7) reset = 1'b1;
    end
    @(negedge clock);
    reset = 1'b0;
    checks++;
    if ({busy, done, plot, vga_x, vga_y, vga_color} !== 21'd0) begin
      failures++;
      $display("FAIL reset_mid got busy=%b done=%b plot=%b x=%0d y=%0d c=%b want all zero",
               busy, done, plot, vga_x, vga_y, vga_color);
    end
    saw_activity = 1'b0;
    repeat (20) begin
      @(negedge clock);
      if (done || busy || plot) saw_activity = 1'b1;
    end
    checks++;
    if (saw_activity !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_quiet got activity=%b want 0", saw_activity);
    end
    start = 1'b1; in_x = 8'd30; in_y = 7'd40; in_color = 3'b110;
    for (int n = 0; n < 16; n++) begin
      @(negedge clock);
      start = 1'b0;
      ex = 8'(30 + n % SIZE);
      ey = 7'(40 + n / SIZE);
      checks++;
      if ({plot, busy, done, vga_x, vga_y, vga_color} !== {exp_plot(n), 1'b1, 1'b0, ex, ey, 3'b110}) begin
        failures++;
        $display("FAIL fresh_px%0d got plot=%b busy=%b done=%b x=%0d y=%0d c=%b want plot=%b busy=1 done=0 x=%0d y=%0d c=110",
                 n, plot, busy, done, vga_x, vga_y, vga_color, exp_plot(n), ex, ey);
      end
    end
    @(negedge clock);
    checks++;
    if ({busy, done, plot} !== 3'b010) begin
      failures++;
      $display("FAIL fresh_done got busy=%b done=%b plot=%b want 010", busy, done, plot);
    end
    @(negedge clock);
  endtask

  // start held high throughout; in_color changed right after acceptance.
  task automatic test_back_to_back();
    logic [7:0] ex;
    logic [6:0] ey;
    start = 1'b1; in_x = 8'd78; in_y = 7'd54; in_color = 3'b010;
    for (int n = 0; n < 16; n++) begin
      @(negedge clock);
      if (n == 0) in_color = 3'b111;
      ex = 8'(78 + n % SIZE);
      ey = 7'(54 + n / SIZE);
      checks++;
      if ({plot, busy, done, vga_x, vga_y, vga_color} !== {exp_plot(n), 1'b1, 1'b0, ex, ey, 3'b010}) begin
        failures++;
        $display("FAIL hold_px%0d got plot=%b busy=%b done=%b x=%0d y=%0d c=%b want plot=%b busy=1 done=0 x=%0d y=%0d c=010",
                 n, plot, busy, done, vga_x, vga_y, vga_color, exp_plot(n), ex, ey);
      end
    end
    @(negedge clock);
    checks++;
    if ({busy, done, plot} !== 3'b010) begin
      failures++;
      $display("FAIL b2b_done got busy=%b done=%b plot=%b want 010", busy, done, plot);
    end
    @(negedge clock);
    checks++;
    if ({busy, done, plot} !== 3'b000) begin
      failures++;
      $display("FAIL b2b_idle got busy=%b done=%b plot=%b want 000", busy, done, plot);
    end
    // 18 cycles after the first acceptance the second square is on the outputs
    @(negedge clock);
    start = 1'b0;
    checks++;
    if ({plot, busy, vga_x, vga_y, vga_color} !== {1'b1, 1'b1, 8'd78, 7'd54, 3'b111}) begin
      failures++;
      $display("FAIL b2b_second got plot=%b busy=%b x=%0d y=%0d c=%b want plot=1 busy=1 x=78 y=54 c=111",
               plot, busy, vga_x, vga_y, vga_color);
    end
    repeat (15) @(negedge clock);
    @(negedge clock);
    checks++;
    if ({busy, done, plot} !== 3'b010) begin
      failures++;
      $display("FAIL b2b_second_done got busy=%b done=%b plot=%b want 010", busy, done, plot);
    end
    @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_filled_and_ignore();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
